// File: rtl/frame_sync_deframer.sv
// frame_sync_deframer
//   Consumes the byte stream from the delay line, hunts for SYNC_BYTE at a
//   period of FRAME_LEN accepted bytes, qualifies lock after LOCK_COUNT
//   consecutive in-period syncs, then forwards payload bytes (positions
//   1..FRAME_LEN-1) with valid / start-of-frame strobes. Isolated sync misses
//   are flywheeled; LOSS_COUNT consecutive misses return to hunt.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data carries a new stream byte this cycle
//   in_data    byte from the delay line output
//   out_data   payload byte (held when out_valid is low)
//   out_valid  single-cycle strobe, out_data valid
//   out_sof    with out_valid on the first payload byte of each frame
//   locked     registered, high while in the LOCKED state
//   err_count  saturating count of missed syncs while locked
//
// Optional feature: define FRAME_SYNC_ERRCNT_EN to build the err_count
// register; otherwise err_count is tied to zero.

module frame_sync_deframer #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned FRAME_LEN  = 20,
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned LOSS_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0] LAST_POS = 8'(FRAME_LEN - 1);
    localparam logic [7:0] LOCK_TGT = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_COUNT);

    logic [1:0] state_q,    state_d;
    logic [7:0] pos_q,      pos_d;
    logic [7:0] hit_cnt_q,  hit_cnt_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       out_sof_q,   out_sof_d;
    logic       locked_q,    locked_d;
    logic       sync_miss;   // LOCKED position-0 mismatch on an accepted byte

    logic [7:0] pos_next;
    logic       is_sync;

    assign pos_next = (pos_q == LAST_POS) ? 8'd0 : pos_q + 8'd1;
    assign is_sync  = (in_data == SYNC_BYTE);

    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        sync_miss   = 1'b0;

        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (is_sync) begin
                        hit_cnt_d  = 8'd1;
                        pos_d      = 8'd1;
                        miss_cnt_d = 8'd0;
                        state_d    = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (pos_q != 8'd0) begin
                        pos_d = pos_next;
                    end else if (is_sync) begin
                        hit_cnt_d = hit_cnt_q + 8'd1;
                        pos_d     = pos_next;
                        if (hit_cnt_q + 8'd1 == LOCK_TGT) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = 8'd0;
                        end
                    end else begin
                        // The failing byte is consumed, not re-examined as a new sync.
                        state_d   = ST_HUNT;
                        hit_cnt_d = 8'd0;
                        pos_d     = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    pos_d = pos_next;
                    if (pos_q == 8'd0) begin
                        if (is_sync) begin
                            miss_cnt_d = 8'd0;
                        end else begin
                            sync_miss  = 1'b1;
                            miss_cnt_d = miss_cnt_q + 8'd1;
                            if (miss_cnt_q + 8'd1 == LOSS_TGT) begin
                                state_d    = ST_HUNT;
                                pos_d      = 8'd0;
                                hit_cnt_d  = 8'd0;
                                miss_cnt_d = 8'd0;
                            end
                        end
                    end else begin
                        out_data_d  = in_data;
                        out_valid_d = 1'b1;
                        out_sof_d   = (pos_q == 8'd1);
                    end
                end
                default: begin
                    state_d    = ST_HUNT;
                    pos_d      = 8'd0;
                    hit_cnt_d  = 8'd0;
                    miss_cnt_d = 8'd0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            pos_q       <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            locked_q    <= locked_d;
        end
    end

`ifdef FRAME_SYNC_ERRCNT_EN
    logic [7:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (sync_miss && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    logic unused_sync_miss;
    assign unused_sync_miss = sync_miss;
    assign err_count        = '0;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_frame_sync_deframer.sv
// Scoreboard bench for frame_sync_deframer: the stimulus script knows which
// bytes must be forwarded and pushes {sof, data} when it drives them; the
// monitor pops on every out_valid.
module tb_frame_sync_deframer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       locked;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    int exp_err = 0;
    logic [8:0] exp_q[$];

    frame_sync_deframer #(
        .SYNC_BYTE (8'hA5),
        .FRAME_LEN (20),
        .LOCK_COUNT(3),
        .LOSS_COUNT(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_sof  (out_sof),
        .locked   (locked),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] err_expected();
`ifdef FRAME_SYNC_ERRCNT_EN
        return (exp_err > 255) ? 32'd255 : 32'(exp_err);
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: outputs are registered, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[7:0]));
                    check("out_sof", 32'(out_sof), 32'(e[8]));
                end
            end else if (out_sof) begin
                check("sof_without_valid", 32'(out_sof), 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit exp_out, input bit exp_sof);
        in_valid = 1'b1;
        in_data  = d;
        if (exp_out) exp_q.push_back({exp_sof, d});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One 20-byte frame: sync byte then 19 payload bytes base, base+1, ...
    task automatic send_frame(input logic [7:0] sync, input bit fwd, input bit exp_lock,
                              input bit miss, input logic [7:0] base, input bit stall);
        logic [7:0] b;
        send(sync, 1'b0, 1'b0);
        if (miss) exp_err++;
        check("locked_after_sync", 32'(locked), 32'(exp_lock));
        check("err_count", 32'(err_count), err_expected());
        if (stall) idle();
        for (int k = 1; k < 20; k++) begin
            b = base + 8'(k - 1);
            send(b, fwd, fwd && (k == 1));
            if (stall) idle();
        end
    endtask

    task automatic no_sync_stream(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send(b, 1'b0, 1'b0);
        end
    endtask

    task automatic drain_check(input string tag);
        idle();
        idle();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sof", 32'(out_sof), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stream without sync: nothing may come out.
        no_sync_stream(45);
        check("nosync_locked", 32'(locked), 32'd0);

        // Lock acquisition: syncs at 0, 20, 40; payload of third frame forwarded.
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
        // Payload containing A5 is ordinary data.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h9A, 1'b0);
        // Flywheel through one miss, then a good sync clears the miss count.
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 8'h30, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h40, 1'b0);
        // Loss after two consecutive misses; the rest of the stream is dropped.
        send_frame(8'h00, 1'b1, 1'b1, 1'b1, 8'h50, 1'b0);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        drain_check("loss_queue_empty");

        // False sync: A5 then 00 one period later, back to hunt; relock at 25/45/65.
        in_valid = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        check("false_sync_locked", 32'(locked), 32'd0);
        for (int i = 0; i < 4; i++) send(8'h5A, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h60, 1'b0);

        // Stall: in_valid toggles every cycle; alignment must hold.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h70, 1'b1);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 8'h90, 1'b1);
        drain_check("stall_queue_empty");
        check("stall_locked", 32'(locked), 32'd1);

        // Reset mid-frame while locked.
        send(8'hA5, 1'b0, 1'b0);
        for (int k = 1; k < 6; k++) send(8'(8'hB0 + k), 1'b1, k == 1);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_err = 0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sof", 32'(out_sof), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_locked", 32'(locked), 32'd0);
        check("async_rst_err", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        no_sync_stream(40);
        drain_check("post_rst_queue_empty");
        check("post_rst_locked", 32'(locked), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
